acc_bus_xfer: RTL and testbench
===============================

// Module: acc_bus_xfer
// PURPOSE
//  Moves a nibble between the accumulator and the external 4-bit data bus over one 8-phase machine cycle.
//  Write direction: drives the latched ACC value onto the bus.
//  Read direction: captures the bus nibble and returns it to the ACC via an rdValid/rdData pulse.
//  Sits between the ACC/temp register block and the bus pads; rdValid drives the ACC write enable.
// PARAMETERS
//  DATA_W      4  bus/ACC nibble width
//  NUM_PHASES  8  phases per machine cycle (A1,A2,A3,M1,M2,X1,X2,X3 = 0..7), must be >=4
//  XFER_PHASE  6  phase index in which data moves (X2); must be 1..NUM_PHASES-2
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rstN          in   1       asynchronous, active-low reset
//  xferReq       in   1       request a transfer; sampled when idle or on the last phase
//  xferWrite     in   1       1 = ACC->bus, 0 = bus->ACC; sampled with xferReq
//  accIn         in   DATA_W  ACC value; latched with xferReq
//  dataBusIn     in   DATA_W  bus value from the pads
//  dataBusOut    out  DATA_W  value driven to the pads
//  dataBusOe     out  1       pad output enable
//  phase         out  PW      current phase, PW = $clog2(NUM_PHASES)
//  cycleSync     out  1       high while busy and phase==0
//  busy          out  1       a machine cycle is in progress
//  rdValid       out  1       1-cycle pulse, rdData valid (read transfers only)
//  rdData        out  DATA_W  captured bus nibble
//  xferDone      out  1       1-cycle pulse on the last phase of every transfer
// BEHAVIOUR
//  Reset (async): state IDLE; phase=0; all outputs 0, including dataBusOut, dataBusOe, rdData and busy.
//  States
//   IDLE: busy=0. If xferReq, latch xferWrite and accIn; next cycle is RUN with phase=0.
//   RUN:  busy=1; phase increments by 1 each clk.
//  Request latency: xferReq at edge N -> busy=1, phase=0, cycleSync=1 after edge N+1.
//  Write transfer: dataBusOe=1 and dataBusOut=latched accIn only while phase==XFER_PHASE.
//   At all other times dataBusOe=0 and dataBusOut=0.
//  Read transfer: dataBusIn is sampled on the edge that leaves phase XFER_PHASE.
//   rdData updates on that edge; rdValid=1 for exactly the next cycle (phase XFER_PHASE+1).
//   rdData holds its value until the next read capture. dataBusOe stays 0 throughout.
//  Last phase (NUM_PHASES-1): xferDone=1.
//   If xferReq is also high: latch new dir/data; phase wraps to 0 (back-to-back, no idle gap).
//   Otherwise return to IDLE.
//  xferReq during RUN other than the last phase: ignored, not queued.
//  Changes to accIn/xferWrite after latching have no effect on the current transfer.
//  Reset mid-transfer: dataBusOe drops immediately (async); no rdValid or xferDone is emitted.
//  Outputs are registered or decoded from state/phase only; no combinational path from inputs.
// CONFIGURATION
//  ACC_BUS_HOLD_EN defined: write transfers also drive in phase XFER_PHASE+1 (hold time for slow RAM).
//   dataBusOe is 1 for 2 cycles. Read timing is unchanged.
//  ACC_BUS_HOLD_EN undefined: drive window is XFER_PHASE only (1 cycle).
// TESTING
//  1 Reset: rstN=0 mid-run -> all outputs 0 at once; after release busy=0, phase=0.
//  2 Write: xferReq=1, xferWrite=1, accIn=4'hA -> Oe=1, Out=4'hA only at phase 6; xferDone at phase 7; busy ends.
//  3 Read: xferWrite=0, dataBusIn=4'h5 at phase 6 -> rdValid pulse at phase 7 with rdData=4'h5; Oe never set.
//  4 Back-to-back: xferReq held high, write 4'h3 then read 4'hC -> phase goes 7->0; cycleSync each cycle; no idle gap.
//  5 Ignored request: xferReq pulse at phase 3 with accIn=4'hF -> current transfer unchanged, IDLE after phase 7.
//  6 ACC_BUS_HOLD_EN build: write 4'h9 -> Oe=1 with Out=4'h9 during phases 6 and 7; read timing as in scenario 3.

Source files
------------

// File: rtl/acc_bus_xfer_if.sv
// Accumulator <-> data bus transfer interface.
// master: requester and pad side; slave: acc_bus_xfer.
interface acc_bus_xfer_if #(
    parameter int DATA_W     = 4,
    parameter int NUM_PHASES = 8
);
    localparam int PW = $clog2(NUM_PHASES);

    logic              xferReq;
    logic              xferWrite;
    logic [DATA_W-1:0] accIn;
    logic [DATA_W-1:0] dataBusIn;
    logic [DATA_W-1:0] dataBusOut;
    logic              dataBusOe;
    logic [PW-1:0]     phase;
    logic              cycleSync;
    logic              busy;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic              xferDone;

    modport master (
        output xferReq, xferWrite, accIn, dataBusIn,
        input  dataBusOut, dataBusOe, phase, cycleSync,
        input  busy, rdValid, rdData, xferDone
    );

    modport slave (
        input  xferReq, xferWrite, accIn, dataBusIn,
        output dataBusOut, dataBusOe, phase, cycleSync,
        output busy, rdValid, rdData, xferDone
    );
endinterface

// File: rtl/acc_bus_xfer.sv
// Moves a nibble between ACC and the data bus over one 8-phase machine cycle.
// Define ACC_BUS_HOLD_EN to extend the write drive window by one phase.
module acc_bus_xfer #(
    parameter int DATA_W     = 4,
    parameter int NUM_PHASES = 8,
    parameter int XFER_PHASE = 6
) (
    input  logic           clk,
    input  logic           rstN,
    acc_bus_xfer_if.slave  bus
);
    localparam int PW = $clog2(NUM_PHASES);

    localparam logic [PW-1:0] LAST_PH = PW'(NUM_PHASES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(NUM_PHASES - 2);
    localparam logic [PW-1:0] X_PH = PW'(XFER_PHASE);
    localparam logic [PW-1:0] PRE_X = PW'(XFER_PHASE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [PW-1:0]     phase;
    logic              busy;
    logic              cycle_sync;
    logic              oe;
    logic [DATA_W-1:0] bus_out;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              wr_lat;
    logic [DATA_W-1:0] acc_lat;

    // Phase sequencer with every output registered one edge ahead of its phase
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            cycle_sync <= 1'b0;
            oe         <= 1'b0;
            bus_out    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
            wr_lat     <= 1'b0;
            acc_lat    <= '0;
        end else begin
            cycle_sync <= 1'b0;
            oe         <= 1'b0;
            bus_out    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    phase <= '0;
                    if (bus.xferReq) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        cycle_sync <= 1'b1;
                        wr_lat     <= bus.xferWrite;
                        acc_lat    <= bus.accIn;
                    end
                end
                RUN: begin
                    if (phase == LAST_PH) begin
                        phase <= '0;
                        if (bus.xferReq) begin
                            cycle_sync <= 1'b1;
                            wr_lat     <= bus.xferWrite;
                            acc_lat    <= bus.accIn;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                        if (wr_lat && phase == PRE_X) begin
                            oe      <= 1'b1;
                            bus_out <= acc_lat;
                        end
`ifdef ACC_BUS_HOLD_EN
                        if (wr_lat && phase == X_PH) begin
                            oe      <= 1'b1;
                            bus_out <= acc_lat;
                        end
`endif
                        if (!wr_lat && phase == X_PH) begin
                            rd_valid <= 1'b1;
                            rd_data  <= bus.dataBusIn;
                        end
                        if (phase == PRE_LAST) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.phase      = phase;
    assign bus.busy       = busy;
    assign bus.cycleSync  = cycle_sync;
    assign bus.dataBusOe  = oe;
    assign bus.dataBusOut = bus_out;
    assign bus.rdValid    = rd_valid;
    assign bus.rdData     = rd_data;
    assign bus.xferDone   = done;
endmodule

// File: tb/tb_acc_bus_xfer.sv
// Directed bench for acc_bus_xfer.
// Checks write, read, back-to-back, ignored request and async reset.
module tb_acc_bus_xfer;
`ifdef ACC_BUS_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk;
    logic rstN;
    int   checks;
    int   passes;

    acc_bus_xfer_if bus_i ();

    acc_bus_xfer dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit drives(input int p);
        return (p == 6) || (HOLD && p == 7);
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, bus_i.busy, 0);
        chk({tag, " phase"}, bus_i.phase, 0);
        chk({tag, " oe"}, bus_i.dataBusOe, 0);
        chk({tag, " out"}, bus_i.dataBusOut, 0);
        chk({tag, " sync"}, bus_i.cycleSync, 0);
        chk({tag, " rdvalid"}, bus_i.rdValid, 0);
        chk({tag, " done"}, bus_i.xferDone, 0);
    endtask

    task automatic start(input bit wr, input logic [3:0] val);
        bus_i.xferReq   = 1'b1;
        bus_i.xferWrite = wr;
        bus_i.accIn     = val;
    endtask

    // One full machine cycle; the request must already be latched
    task automatic run_xfer(input bit wr, input logic [3:0] val,
                            input bit poke, input bit nreq,
                            input bit nwr, input logic [3:0] nval);
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            chk("phase", bus_i.phase, p);
            chk("busy", bus_i.busy, 1);
            chk("sync", bus_i.cycleSync, p == 0);
            chk("oe", bus_i.dataBusOe, wr && drives(p));
            chk("out", bus_i.dataBusOut,
                (wr && drives(p)) ? val : 4'h0);
            chk("rdvalid", bus_i.rdValid, !wr && p == 7);
            if (!wr && p == 7) chk("rddata", bus_i.rdData, val);
            chk("done", bus_i.xferDone, p == 7);
            bus_i.xferReq   = 1'b0;
            bus_i.xferWrite = ~wr;
            bus_i.accIn     = 4'h0;
            bus_i.dataBusIn = (p == 6) ? val : ~val;
            if (poke && p == 3) start(1'b1, 4'hF);
            if (nreq && p == 7) start(nwr, nval);
        end
    endtask

    initial begin
        clk             = 1'b0;
        rstN            = 1'b0;
        checks          = 0;
        passes          = 0;
        bus_i.xferReq   = 1'b0;
        bus_i.xferWrite = 1'b0;
        bus_i.accIn     = 4'h0;
        bus_i.dataBusIn = 4'h0;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset rddata", bus_i.rdData, 0);
        rstN = 1'b1;
        @(negedge clk);
        chk_quiet("idle");

        start(1'b1, 4'hA);
        run_xfer(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk_quiet("after write");

        start(1'b0, 4'h0);
        run_xfer(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk_quiet("after read");
        chk("rddata hold", bus_i.rdData, 4'h5);

        start(1'b1, 4'h3);
        run_xfer(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0);
        run_xfer(1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk_quiet("after b2b");
        chk("b2b rddata", bus_i.rdData, 4'hC);

        start(1'b1, 4'h2);
        run_xfer(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk_quiet("after ignored");

        start(1'b1, 4'h7);
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            bus_i.xferReq = 1'b0;
            chk("mid phase", bus_i.phase, p);
        end
        chk("mid oe", bus_i.dataBusOe, 1);
        chk("mid out", bus_i.dataBusOut, 4'h7);
        #2 rstN = 1'b0;
        #1;
        chk_quiet("async reset");
        chk("async rddata", bus_i.rdData, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk_quiet("post reset");
        @(negedge clk);
        chk_quiet("post reset 2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
